// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side buses of the instruction cache.
// slave is the cache view, master is the fetcher/memory view.
interface inst_cache_if #(
    parameter int ADDR_BITS = 32
);
    logic                 _clear;
    logic                 _InstFetcher_need_inst;
    logic [ADDR_BITS-1:0] _next_pc;
    logic                 _inst_ready_in;
    logic [31:0]          _inst_in;
    logic                 _mem_busy;
    logic                 _icache_mem_req;
    logic [ADDR_BITS-1:0] _icache_mem_addr;
    logic                 _mem_line_valid;
    logic [127:0]         _mem_line_data;

    modport slave (
        input  _clear,
        input  _InstFetcher_need_inst,
        input  _next_pc,
        output _inst_ready_in,
        output _inst_in,
        output _mem_busy,
        output _icache_mem_req,
        output _icache_mem_addr,
        input  _mem_line_valid,
        input  _mem_line_data
    );

    modport master (
        output _clear,
        output _InstFetcher_need_inst,
        output _next_pc,
        input  _inst_ready_in,
        input  _inst_in,
        input  _mem_busy,
        input  _icache_mem_req,
        input  _icache_mem_addr,
        output _mem_line_valid,
        output _mem_line_data
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with 16-byte lines.
// Serves 2-byte-aligned fetches, including windows straddling two lines.
module inst_cache #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_BITS  = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    inst_cache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int IW    = (INDEX_BITS > 0) ? INDEX_BITS : 1;
    localparam int TW    = ADDR_BITS - 4 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL0, FILL1, RESP} state_e;

    state_e state_q, state_d;

    logic [127:0]         data_q [LINES];
    logic [TW-1:0]        tag_q  [LINES];
    logic [LINES-1:0]     valid_q;

    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 req_q, req_d;
    logic                 ready_q, ready_d;
    logic [31:0]          inst_q, inst_d;
    logic                 flush_q, flush_d;
    logic [127:0]         fill0_q, fill0_d;

    logic                 we;
    logic [IW-1:0]        widx;
    logic [TW-1:0]        wtag;
    logic [127:0]         wdata;

    logic [ADDR_BITS-1:0] pc_sel, line0, line1;
    logic [IW-1:0]        idx0, idx1;
    logic [TW-1:0]        tag0, tag1;
    logic                 strad, hit0, hit1, hit1_post;
    logic                 accept, fill_ack, stop;
    logic [127:0]         lo_line, hi_line;

    function automatic logic [IW-1:0] idx_of(logic [ADDR_BITS-1:0] a);
        if (INDEX_BITS == 0) return '0;
        return IW'(a >> 4);
    endfunction

    function automatic logic [TW-1:0] tag_of(logic [ADDR_BITS-1:0] a);
        return TW'(a >> (4 + INDEX_BITS));
    endfunction

    function automatic logic [31:0] window(
        logic [127:0] lo,
        logic [127:0] hi,
        logic [3:0]   off
    );
        if (off == 4'd14) return {hi[15:0], lo[127:112]};
        return 32'(lo >> {off, 3'b000});
    endfunction

    // Lookups only happen in IDLE; other states re-derive from the latched pc.
    always_comb begin
        pc_sel    = (state_q == IDLE) ? bus._next_pc : pc_q;
        line0     = {pc_sel[ADDR_BITS-1:4], 4'b0000};
        line1     = line0 + ADDR_BITS'(16);
        idx0      = idx_of(line0);
        idx1      = idx_of(line1);
        tag0      = tag_of(line0);
        tag1      = tag_of(line1);
        strad     = (pc_sel[3:0] == 4'd14);
        hit0      = valid_q[idx0] && (tag_q[idx0] == tag0);
        hit1      = valid_q[idx1] && (tag_q[idx1] == tag1);
        hit1_post = (idx1 == idx0) ? (tag1 == tag0) : hit1;
        lo_line   = (state_q == RESP && idx0 == idx1) ? fill0_q
                                                      : data_q[idx0];
        hi_line   = data_q[idx1];
        accept    = bus._InstFetcher_need_inst && rdy_in && !bus._clear;
        fill_ack  = bus._mem_line_valid && rdy_in && req_q;
        stop      = flush_q || bus._clear;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    if (accept && !hit0)               state_d = FILL0;
                    else if (accept && strad && !hit1) state_d = FILL1;
                end
                FILL0: begin
                    if (fill_ack) begin
                        if (stop)                      state_d = IDLE;
                        else if (strad && !hit1_post)  state_d = FILL1;
                        else                           state_d = RESP;
                    end
                end
                FILL1: begin
                    if (fill_ack) state_d = stop ? IDLE : RESP;
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        ready_d = ready_q;
        inst_d  = inst_q;
        flush_d = flush_q;
        fill0_d = fill0_q;
        we      = 1'b0;
        widx    = idx0;
        wtag    = tag0;
        wdata   = bus._mem_line_data;
        if (rdy_in) begin
            ready_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    flush_d = 1'b0;
                    if (accept) begin
                        pc_d = bus._next_pc;
                        if (!hit0) begin
                            req_d  = 1'b1;
                            addr_d = line0;
                        end else if (strad && !hit1) begin
                            req_d  = 1'b1;
                            addr_d = line1;
                        end else begin
                            ready_d = 1'b1;
                            inst_d  = window(lo_line, hi_line, pc_sel[3:0]);
                        end
                    end
                end
                FILL0: begin
                    if (bus._clear) flush_d = 1'b1;
                    if (fill_ack) begin
                        we      = 1'b1;
                        fill0_d = bus._mem_line_data;
                        req_d   = 1'b0;
                        flush_d = 1'b0;
                        if (!stop && strad && !hit1_post) addr_d = line1;
                    end
                end
                FILL1: begin
                    if (bus._clear) flush_d = 1'b1;
                    widx = idx1;
                    wtag = tag1;
                    // req idles one cycle between back-to-back fills
                    if (fill_ack) begin
                        we      = 1'b1;
                        req_d   = 1'b0;
                        flush_d = 1'b0;
                    end else if (!req_q) begin
                        req_d = 1'b1;
                    end
                end
                RESP: begin
                    if (!bus._clear) begin
                        ready_d = 1'b1;
                        inst_d  = window(lo_line, hi_line, pc_sel[3:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus._inst_ready_in   = ready_q && rdy_in;
        bus._inst_in         = inst_q;
        bus._mem_busy        = (state_q != IDLE);
        bus._icache_mem_req  = req_q;
        bus._icache_mem_addr = addr_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            inst_q  <= '0;
            flush_q <= 1'b0;
            fill0_q <= '0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            inst_q  <= inst_d;
            flush_q <= flush_d;
            fill0_q <= fill0_d;
            if (we) valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we && !rst_in) begin
            data_q[widx] <= wdata;
            tag_q[widx]  <= wtag;
        end
    end
endmodule
